// File: rtl/jogo_pkg.sv
// Shared constants for the memory-sequence game datapath: widths, sequence
// length and the fixed expected-play ROM.
package jogo_pkg;

  localparam int W_DADO = 4;
  localparam int N_END  = 16;
  localparam int W_END  = $clog2(N_END);

  // Packed ROM image, address 0 in the least significant nibble.
  localparam logic [N_END*W_DADO-1:0] ROM_CONTEUDO = {
    4'b0100, 4'b0001, 4'b1000, 4'b1000,
    4'b0100, 4'b0100, 4'b0010, 4'b0010,
    4'b0001, 4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  function automatic logic [W_DADO-1:0] rom_ler(input logic [W_END-1:0] endereco);
    return ROM_CONTEUDO[endereco*W_DADO +: W_DADO];
  endfunction

endpackage

// File: rtl/detector_jogada.sv
// Two-stage button synchronizer plus a rising-edge detector on "any button
// pressed", giving one jogada pulse per press however long it is held.
module detector_jogada
  import jogo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [W_DADO-1:0] botoes,
  output logic [W_DADO-1:0] botoes_sinc,
  output logic              jogada
);

  logic [W_DADO-1:0] s1_reg;
  logic [W_DADO-1:0] s2_reg;
  logic              b_any;
  logic              b_any_prev_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_reg         <= '0;
      s2_reg         <= '0;
      b_any_prev_reg <= 1'b0;
    end else begin
      s1_reg         <= botoes;
      s2_reg         <= s1_reg;
      b_any_prev_reg <= b_any;
    end
  end

  // Edge on the OR of all buttons, so adding a second button mid-press is silent.
  assign b_any       = |s2_reg;
  assign jogada      = b_any & ~b_any_prev_reg;
  assign botoes_sinc = s2_reg;

endmodule

// File: rtl/fluxo_dados_jogo.sv
// Game datapath: ROM address counter, play register and comparator driven by
// the control FSM, plus the button-press detector.
module fluxo_dados_jogo
  import jogo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [W_DADO-1:0] botoes,
  input  logic              zeraC,
  input  logic              contaC,
  input  logic              zeraR,
  input  logic              registraR,
  output logic              jogada,
  output logic              igual,
  output logic              fim,
  output logic [W_END-1:0]  db_contagem,
  output logic [W_DADO-1:0] db_memoria,
  output logic [W_DADO-1:0] db_jogada
);

  logic [W_END-1:0]  contagem_reg, contagem_next;
  logic [W_DADO-1:0] jogada_reg, jogada_next;
  logic [W_DADO-1:0] botoes_sinc;
  logic [W_DADO-1:0] dado_rom;

  detector_jogada u_detector (
    .clock       (clock),
    .reset       (reset),
    .botoes      (botoes),
    .botoes_sinc (botoes_sinc),
    .jogada      (jogada)
  );

  // Clears take priority over count/load; the counter wraps naturally.
  always_comb begin
    contagem_next = contagem_reg;
    if (zeraC)
      contagem_next = '0;
    else if (contaC)
      contagem_next = contagem_reg + W_END'(1);
  end

  always_comb begin
    jogada_next = jogada_reg;
    if (zeraR)
      jogada_next = '0;
    else if (registraR)
      jogada_next = botoes_sinc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_reg <= '0;
      jogada_reg   <= '0;
    end else begin
      contagem_reg <= contagem_next;
      jogada_reg   <= jogada_next;
    end
  end

  assign dado_rom    = rom_ler(contagem_reg);
  assign igual       = (jogada_reg == dado_rom);
  assign fim         = (contagem_reg == W_END'(N_END - 1));
  assign db_contagem = contagem_reg;
  assign db_memoria  = dado_rom;
  assign db_jogada   = jogada_reg;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Self-checking bench for fluxo_dados_jogo: directed scenarios and random
// traffic compared against a cycle-level behavioural model of the game datapath.
module tb_fluxo_dados_jogo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic       zeraC = 1'b0, contaC = 1'b0, zeraR = 1'b0, registraR = 1'b0;
  logic       jogada, igual, fim;
  logic [3:0] db_contagem, db_memoria, db_jogada;

  int checks = 0;
  int errors = 0;

  fluxo_dados_jogo dut (
    .clock       (clock),
    .reset       (reset),
    .botoes      (botoes),
    .zeraC       (zeraC),
    .contaC      (contaC),
    .zeraR       (zeraR),
    .registraR   (registraR),
    .jogada      (jogada),
    .igual       (igual),
    .fim         (fim),
    .db_contagem (db_contagem),
    .db_memoria  (db_memoria),
    .db_jogada   (db_jogada)
  );

  always #5 clock = ~clock;

  // Observed outputs packed as {jogada, igual, fim, contagem, memoria, jogada_reg}
  logic [14:0] obs;
  assign obs = {jogada, igual, fim, db_contagem, db_memoria, db_jogada};

  // ---- behavioural model ----
  logic [3:0] rom [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                           4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
  int         m_count;
  logic [3:0] m_play;
  logic [3:0] hist [3];  // botoes seen at the last three edges, newest first

  task automatic model_reset();
    m_count = 0;
    m_play  = 4'b0000;
    for (int i = 0; i < 3; i++) hist[i] = 4'b0000;
  endtask

  function automatic logic [14:0] expect_out();
    logic       e_jog;
    logic [3:0] e_rom;
    e_jog = (hist[1] != 4'b0000) && (hist[2] == 4'b0000);
    e_rom = rom[m_count];
    return {e_jog, m_play == e_rom, m_count == 15, 4'(m_count), e_rom, m_play};
  endfunction

  // One clock edge with the current inputs, then advance the model.
  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else begin
      if (zeraR) m_play = 4'b0000;
      else if (registraR) m_play = hist[1];
      if (zeraC) m_count = 0;
      else if (contaC) m_count = (m_count + 1) % 16;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = botoes;
    end
    #1;
  endtask

  task automatic idle_inputs();
    zeraC = 0; contaC = 0; zeraR = 0; registraR = 0;
  endtask

  task automatic go_to_address(input int a);
    idle_inputs();
    zeraC = 1; tick(); zeraC = 0;
    contaC = 1;
    for (int i = 0; i < a; i++) tick();
    contaC = 0;
  endtask

  task automatic test_reset();
    reset = 0; botoes = 4'b1111; idle_inputs();
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (obs !== 15'b000_0000_0001_0000) begin
      errors++;
      $display("FAIL reset_values: got %b required %b", obs, 15'b000_0000_0001_0000);
    end
    checks++;
    if (obs !== expect_out()) begin
      errors++;
      $display("FAIL reset_model: got %b required %b", obs, expect_out());
    end
  endtask

  task automatic test_edge_latency();
    int pulses, first;
    botoes = 4'b0000;
    reset = 1;
    tick(); tick();
    pulses = 0; first = -1;
    botoes = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (jogada) begin pulses++; if (first < 0) first = i; end
      checks++;
      if (obs !== expect_out()) begin
        errors++;
        $display("FAIL edge_press1 cycle %0d: got %b required %b", i, obs, expect_out());
      end
    end
    checks++;
    if (pulses !== 1 || first !== 2) begin
      errors++;
      $display("FAIL edge_latency: got %0d pulses first at %0d required 1 pulse at 2", pulses, first);
    end
    botoes = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    pulses = 0;
    botoes = 4'b0010;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (jogada) pulses++;
      if (i == 3) botoes = 4'b0011;  // second button while held: no new pulse
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL edge_second_press: got %0d pulses required 1", pulses);
    end
    botoes = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_counter();
    go_to_address(15);
    checks++;
    if (db_contagem !== 4'd15 || fim !== 1'b1 || db_memoria !== 4'b0100) begin
      errors++;
      $display("FAIL counter_end: got cnt=%0d fim=%b mem=%b required 15 1 0100", db_contagem, fim, db_memoria);
    end
    contaC = 1; tick(); contaC = 0;
    checks++;
    if (db_contagem !== 4'd0 || fim !== 1'b0 || obs !== expect_out()) begin
      errors++;
      $display("FAIL counter_wrap: got cnt=%0d fim=%b required 0 0", db_contagem, fim);
    end
    go_to_address(5);
    zeraC = 1; contaC = 1; tick(); idle_inputs();
    checks++;
    if (db_contagem !== 4'd0 || obs !== expect_out()) begin
      errors++;
      $display("FAIL counter_clear_priority: got cnt=%0d required 0", db_contagem);
    end
  endtask

  task automatic test_register_compare();
    go_to_address(3);
    botoes = 4'b1000; for (int i = 0; i < 3; i++) tick();
    registraR = 1; tick(); registraR = 0;
    checks++;
    if (db_jogada !== 4'b1000 || igual !== 1'b1 || obs !== expect_out()) begin
      errors++;
      $display("FAIL reg_match: got play=%b igual=%b required 1000 1", db_jogada, igual);
    end
    botoes = 4'b0000; for (int i = 0; i < 3; i++) tick();
    botoes = 4'b0100; for (int i = 0; i < 3; i++) tick();
    registraR = 1; tick(); registraR = 0;
    checks++;
    if (db_jogada !== 4'b0100 || igual !== 1'b0 || obs !== expect_out()) begin
      errors++;
      $display("FAIL reg_mismatch: got play=%b igual=%b required 0100 0", db_jogada, igual);
    end
    zeraR = 1; registraR = 1; tick(); idle_inputs();
    checks++;
    if (db_jogada !== 4'b0000 || obs !== expect_out()) begin
      errors++;
      $display("FAIL reg_clear_priority: got play=%b required 0000", db_jogada);
    end
    botoes = 4'b0000; for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_full_game();
    go_to_address(0);
    for (int a = 0; a < 16; a++) begin
      botoes = rom[a]; for (int i = 0; i < 3; i++) tick();
      registraR = 1; tick(); registraR = 0;
      checks++;
      if (igual !== 1'b1 || fim !== (a == 15) || db_contagem !== 4'(a)) begin
        errors++;
        $display("FAIL game_addr%0d: got igual=%b fim=%b cnt=%0d required 1 %b %0d",
                 a, igual, fim, db_contagem, a == 15, a);
      end
      botoes = 4'b0000; contaC = 1; tick(); contaC = 0; tick(); tick();
    end
  endtask

  task automatic test_async_reset();
    go_to_address(7);
    botoes = 4'b0001; for (int i = 0; i < 3; i++) tick();
    registraR = 1; tick(); registraR = 0;
    checks++;
    if (db_jogada !== 4'b0001 || db_contagem !== 4'd7) begin
      errors++;
      $display("FAIL async_setup: got play=%b cnt=%0d required 0001 7", db_jogada, db_contagem);
    end
    #2 reset = 0;
    #1;
    model_reset();
    checks++;
    if (obs !== 15'b000_0000_0001_0000) begin
      errors++;
      $display("FAIL async_reset: got %b required %b", obs, 15'b000_0000_0001_0000);
    end
    tick();
    reset = 1; botoes = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: botoes = 4'b0000;
        1, 2: botoes = 4'b0001 << $urandom_range(0, 3);
        default: botoes = 4'($urandom);
      endcase
      zeraC     = ($urandom_range(0, 15) == 0);
      contaC    = ($urandom_range(0, 2) == 0);
      zeraR     = ($urandom_range(0, 15) == 0);
      registraR = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (obs !== expect_out()) begin
        errors++;
        $display("FAIL random_step%0d: got %b required %b", i, obs, expect_out());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_counter();
    test_register_compare();
    test_full_game();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fluxo_dados_jogo.md
Name: fluxo_dados_jogo

Overview:
Datapath for the memory-sequence game. It works alongside the game control FSM: it consumes zeraC, contaC, zeraR and registraR, and produces jogada, igual and fim for the FSM.
It contains:
- an address counter over a fixed 16-entry expected-play ROM
- a synchronizer and rising-edge detector on the button bus
- a play register
- an equality comparator
Debug outputs expose the counter, the ROM data and the registered play for the board displays.

Parameters:
N_END, 16, number of ROM addresses (sequence length); address width is log2(N_END) = 4
W_DADO, 4, width of buttons, ROM words and play register

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all state while low
botoes  in  4  raw push buttons (asynchronous, one-hot when pressed)
zeraC  in  1  synchronous clear of address counter
contaC  in  1  increment address counter
zeraR  in  1  synchronous clear of play register
registraR  in  1  load play register
jogada  out  1  one-cycle pulse: a button press was detected
igual  out  1  registered play equals ROM word at current address
fim  out  1  address counter is at N_END-1
db_contagem  out  4  current address
db_memoria  out  4  ROM word at current address
db_jogada  out  4  play register contents

Behaviour:
Reset (reset=0, async):
- counter=0, play register=0, synchronizer flops=0, edge-history flop=0.
- Hence: jogada=0, db_contagem=0, db_jogada=0, fim=0, db_memoria=4'b0001, igual=0.
- Reset asserted mid-game aborts immediately; there is no partial state.

Address counter:
- 4-bit.
- zeraC has priority over contaC: if zeraC=1, count<=0.
- Else if contaC=1, count<=count+1, wrapping 15->0.
- Else hold.
- fim = (count == N_END-1); combinational from the counter.

ROM:
- Combinational, address = count.
- Contents, addr 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.

Synchronizer:
- botoes passes through two flip-flop stages (s1 then s2), full 4-bit bus.
- b_any = OR of s2 bits.
- A history flop holds the previous b_any.

Edge detect:
- jogada = b_any & ~b_any_prev.
- High for exactly one cycle per press, regardless of hold length.
- Latency: botoes stable before edge k -> jogada high between edges k+1 and k+2.
- A release followed by a new press produces a new pulse.
- Holding a button produces no further pulses.
- A second button added while the first is still held produces no pulse (b_any stays 1).

Play register:
- zeraR has priority over registraR: if zeraR=1, reg<=0.
- Else if registraR=1, reg<=s2, i.e. the synchronized bus, not raw botoes.
- Else hold.

Comparator:
- igual = (reg == ROM[count]); combinational, full 4-bit equality.
- Multi-button plays (e.g. 0011) never match.

Simultaneous zeraC and contaC: clear wins. The same rule applies to zeraR and registraR.

No handshake beyond the pulse. The FSM samples registraR at least 2 cycles after jogada, so s2 is stable when captured.

Decomposition:
- Shared package (jogo_pkg): W_DADO, N_END, the 16-word ROM contents constant, address width.
- One sub-module: detector_jogada. It holds the two-stage synchronizer, OR-reduction, history flop and edge pulse, and exports the synchronized bus and jogada.
- Counter, ROM, register and comparator stay inline.

Test Plan:
- Reset: hold reset=0 with botoes=1111 for 3 cycles -> jogada=0, db_contagem=0, db_jogada=0, db_memoria=0001, igual=0, fim=0.
- Edge latency: release reset, drive botoes=0001 for 10 cycles -> jogada high exactly one cycle, 2 cycles after the change. Release 3 cycles, press 0010 -> a second single pulse.
- Counter: zeraC pulse, then contaC for 15 cycles -> db_contagem 15, fim=1, db_memoria=0100. One more contaC -> count 0, fim=0. zeraC and contaC together at count 5 -> count 0.
- Register and compare: at address 3, press 1000, registraR one cycle -> db_jogada=1000, igual=1. Press 0100, registraR -> igual=0. zeraR and registraR together -> db_jogada=0000.
- Full correct game: for each address 0..15, press the ROM word, registraR, check igual=1, contaC -> all 16 match; fim=1 only at address 15.
- Async reset mid-operation: at address 7 with db_jogada=0001, pull reset low between clock edges -> all outputs return to reset values without waiting for a clock edge.
